// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch state encoding, instruction width,
// the default halt encoding and the opcodes the control block decodes.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // True when a byte address lies outside an instruction memory of the given depth.
  function automatic logic beyond_imem(input logic [31:0] addr, input int words);
    return addr[31:2] >= 30'(words);
  endfunction

endpackage

// File: rtl/fetch_controller_npc_select.sv
// npc_select: combinational next-PC candidates for the fetch controller.
// Produces pc+4 and the redirect target (jump has priority over branch).
module npc_select
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] pc,
  input  logic               branch_taken,
  input  logic [31:0]        branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic               redirect,
  output logic [INSTR_W-1:0] target
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Sequential address, both redirect targets, and the jump-over-branch pick.
  always_comb begin
    pc_plus4      = pc + 32'd4;
    // Shifting the whole word drops bits 31:30, same as using branch_imm[29:0].
    branch_target = pc_plus4 + (branch_imm << 2);
    jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    redirect      = jump | branch_taken;
    target        = jump ? jump_target : branch_target;
  end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer, owns the PC.
// States: BOOT (one idle cycle) -> RUN <-> STALL; RUN -> HALT (exit only by rst).
// Optional feature macro: BRANCH_DELAY_SLOT_EN (one delay slot after a taken
// branch/jump; the target is held in a pending register until the slot fetches).
module fetch_controller
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 16,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_valid,
  output logic               halted
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  cand;
  logic         redirect;
  logic [31:0]  target;

`ifdef BRANCH_DELAY_SLOT_EN
  logic         pend_valid, pend_valid_next;
  logic [31:0]  pend_target, pend_target_next;
`endif

  npc_select u_npc (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .target       (target)
  );

  // Next state and next PC; halt detection takes priority over stall and redirect.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cand       = pc_plus4;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
`endif
    case (state)
      BOOT:  state_next = RUN;
      RUN: begin
        if (instruction == HALT_WORD) begin
          state_next = HALT;
        end else if (stall) begin
          state_next = STALL;
        end else begin
`ifdef BRANCH_DELAY_SLOT_EN
          if (pend_valid) begin
            cand            = pend_target;
            pend_valid_next = 1'b0;
          end else if (redirect) begin
            cand             = pc_plus4;
            pend_valid_next  = 1'b1;
            pend_target_next = target;
          end
`else
          if (redirect) cand = target;
`endif
          if (beyond_imem(cand, IMEM_WORDS)) state_next = HALT;
          else                               pc_next    = cand;
        end
      end
      STALL: if (!stall) state_next = RUN;
      HALT:  state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // State, PC and pending-redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
`endif
    end
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the fetch rules.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_known  = 0;
  bit          m_boot   = 0;
  bit          m_stall  = 0;
  bit          m_halt   = 0;
  bit          m_pend   = 0;
  logic [31:0] m_pc     = 32'd0;
  logic [31:0] m_tgt    = 32'd0;

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (16),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare outputs to the model, clock, advance the model.
  task automatic step(input logic r, input logic [31:0] ins, input logic st,
                      input logic br, input logic [31:0] imm,
                      input logic jp, input logic [25:0] idx);
    logic [31:0] nxt;
    @(negedge clk);
    rst = r; instruction = ins; stall = st;
    branch_taken = br; branch_imm = imm; jump = jp; jump_index = idx;
    #1;
    if (m_known) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, !(m_boot || m_stall || m_halt)});
      check("halted", {31'd0, halted}, {31'd0, m_halt});
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_pc = 32'd0; m_boot = 1; m_stall = 0; m_halt = 0; m_pend = 0;
    end else if (m_known && !m_halt) begin
      if (m_boot) m_boot = 0;
      else if (m_stall) begin
        if (!st) m_stall = 0;
      end else if (ins == 32'hFFFF_FFFF) m_halt = 1;
      else if (st) m_stall = 1;
      else begin
`ifdef BRANCH_DELAY_SLOT_EN
        if (m_pend) begin
          nxt = m_tgt; m_pend = 0;
        end else begin
          nxt = m_pc + 32'd4;
          if (jp) begin
            m_tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4); m_pend = 1;
          end else if (br) begin
            m_tgt = m_pc + 32'd4 + imm * 32'd4; m_pend = 1;
          end
        end
`else
        if (jp)      nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
        else if (br) nxt = m_pc + 32'd4 + imm * 32'd4;
        else         nxt = m_pc + 32'd4;
`endif
        if ((nxt / 32'd4) >= 32'd16) m_halt = 1;
        else m_pc = nxt;
      end
    end
    #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 32'd0, 0, 26'd0);
  endtask

  initial begin
    rst = 1; instruction = 0; stall = 0; branch_taken = 0;
    branch_imm = 0; jump = 0; jump_index = 0;

    // reset and boot cycle
    step(1, 32'd0, 0, 0, 32'd0, 0, 26'd0);
    step(1, 32'd0, 0, 0, 32'd0, 0, 26'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    plain(1);
    check("boot_done_fv", {31'd0, fetch_valid}, 32'd1);
    check("boot_pc", pc, 32'h0);

    // sequential
    plain(1); check("seq_4", pc, 32'h04);
    plain(1); check("seq_8", pc, 32'h08);
    plain(1); check("seq_c", pc, 32'h0C);

    // branch at 0x0C, offset 1
    step(0, 32'd0, 0, 1, 32'd1, 0, 26'd0);
`ifdef BRANCH_DELAY_SLOT_EN
    check("br_slot", pc, 32'h10);
    plain(1);
`endif
    check("br_tgt", pc, 32'h14);

    // jump at 0x20 to word 2
    plain(3); check("pre_jmp", pc, 32'h20);
    step(0, 32'd0, 0, 0, 32'd0, 1, 26'h2);
`ifdef BRANCH_DELAY_SLOT_EN
    check("jmp_slot", pc, 32'h24);
    plain(1);
`endif
    check("jmp_tgt", pc, 32'h08);
    step(0, 32'd0, 0, 1, 32'd5, 1, 26'h2);
`ifdef BRANCH_DELAY_SLOT_EN
    plain(1);
`endif
    check("jmp_br", pc, 32'h08);

    // stall three cycles at 0x10
    plain(2); check("pre_stall", pc, 32'h10);
    for (int i = 0; i < 3; i++) step(0, 32'd0, 1, 1, 32'd3, 1, 26'h1);
    check("stall_pc", pc, 32'h10);
    check("stall_fv", {31'd0, fetch_valid}, 32'd0);
    plain(1); check("unstall_pc", pc, 32'h10);
    plain(1); check("post_stall", pc, 32'h14);

    // halt word at 0x08
    step(1, 32'd0, 0, 0, 32'd0, 0, 26'd0);
    plain(3); check("pre_hw", pc, 32'h08);
    step(0, 32'hFFFF_FFFF, 1, 0, 32'd0, 0, 26'd0);
    check("hw_halted", {31'd0, halted}, 32'd1);
    check("hw_pc", pc, 32'h08);
    plain(3); check("hw_sticky", {31'd0, halted}, 32'd1);

    // out of range sequential halt
    step(1, 32'd0, 0, 0, 32'd0, 0, 26'd0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_halted", {31'd0, halted}, 32'd0);
    plain(16); check("end_pc", pc, 32'h3C);
    plain(1);
    check("oor_halted", {31'd0, halted}, 32'd1);
    check("oor_pc", pc, 32'h3C);

    // random traffic
    step(1, 32'd0, 0, 0, 32'd0, 0, 26'd0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, st, br, jp;
      logic [31:0] ins, imm;
      logic [25:0] idx;
      r   = ($urandom_range(0, 99) < 2);
      ins = ($urandom_range(0, 99) < 2) ? 32'hFFFF_FFFF : $urandom;
      st  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 15);
      jp  = ($urandom_range(0, 99) < 10);
      imm = 32'($urandom_range(0, 12)) - 32'd6;
      idx = 26'($urandom_range(0, 20));
      step(r, ins, st, br, imm, jp, idx);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
